// File: rtl/puf_pkg.sv
// Shared definitions for the DelayPUF sweep controller.
//   sweep_state_t      : controller state encoding
//   DEFAULT_PUF_LENGTH : default challenge width
//   MIN_SETTLE         : smallest legal settle time (2-flop sync + margin)
//   sig_width()        : signature width for a given challenge width
package puf_pkg;

  localparam int unsigned DEFAULT_PUF_LENGTH = 8;
  localparam int unsigned MIN_SETTLE         = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_SETTLE,
    ST_SAMPLE,
    ST_FINISH
  } sweep_state_t;

  function automatic int unsigned sig_width(input int unsigned len);
    return 32'd1 << len;
  endfunction

endpackage

// File: rtl/puf_sweep_ctrl.sv
// Sweep controller placed directly upstream of DelayPUF.
// On a start pulse it walks every challenge. For each challenge it raises
// puf_run for RUN_CYCLES cycles, then lowers it for SETTLE_CYCLES cycles,
// then samples puf_result for one cycle. Each sample is shifted into the
// signature, so bit i ends up holding the response to challenge i.
//
// Ports:
//   clk           : single clock, shared with the DelayPUF synchronizers
//   reset         : asynchronous, active-high
//   start         : one-cycle sweep request, honoured only in IDLE
//   busy          : high while a sweep is in progress (RUN/SETTLE/SAMPLE)
//   done          : one-cycle pulse; the signature is final in this cycle
//   signature     : collected responses, SIG_W = 2**PUF_LENGTH bits
//   puf_challenge : challenge driven to DelayPUF
//   puf_run       : run strobe driven to DelayPUF
//   puf_result    : already-synchronized response from DelayPUF
module puf_sweep_ctrl
  import puf_pkg::*;
#(
  parameter int unsigned PUF_LENGTH    = DEFAULT_PUF_LENGTH,
  parameter int unsigned RUN_CYCLES    = 10,
  parameter int unsigned SETTLE_CYCLES = 10,
  localparam int unsigned SIG_W        = sig_width(PUF_LENGTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [SIG_W-1:0]      signature,
  output logic [PUF_LENGTH-1:0] puf_challenge,
  output logic                  puf_run,
  input  logic                  puf_result
);

  localparam int unsigned PH_MAX = (RUN_CYCLES > SETTLE_CYCLES) ? RUN_CYCLES : SETTLE_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0] RUN_LAST    = PH_W'(RUN_CYCLES - 1);
  localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);

  if (RUN_CYCLES < 1) begin : g_bad_run
    $error("puf_sweep_ctrl: RUN_CYCLES must be at least 1");
  end

  if (SETTLE_CYCLES < MIN_SETTLE) begin : g_bad_settle
    $error("puf_sweep_ctrl: SETTLE_CYCLES must cover the DelayPUF synchronizer (>= MIN_SETTLE)");
  end

  sweep_state_t            state_q, state_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [PUF_LENGTH-1:0]   chal_q,  chal_d;
  logic [SIG_W-1:0]        sig_q,   sig_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      chal_q  <= '0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      chal_q  <= chal_d;
      sig_q   <= sig_d;
    end
  end

  // Outputs are decoded from state only, so reset drops puf_run immediately
  // and the challenge can only move on the SAMPLE->RUN edge.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    chal_d  = chal_q;
    sig_d   = sig_q;
    busy    = 1'b0;
    done    = 1'b0;
    puf_run = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          phase_d = '0;
          chal_d  = '0;
          sig_d   = '0;
        end
      end

      ST_RUN: begin
        busy    = 1'b1;
        puf_run = 1'b1;
        if (phase_q == RUN_LAST) begin
          state_d = ST_SETTLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      ST_SETTLE: begin
        busy = 1'b1;
        if (phase_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      ST_SAMPLE: begin
        busy  = 1'b1;
        sig_d = {puf_result, sig_q[SIG_W-1:1]};
        if (&chal_q) begin
          state_d = ST_FINISH;
        end else begin
          chal_d  = chal_q + 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign signature     = sig_q;
  assign puf_challenge = chal_q;

endmodule

// File: tb/tb_puf_sweep_ctrl.sv
// Directed bench for puf_sweep_ctrl: reset values, async abort, LSB-pattern
// sweep with start-handling, a second sweep, and a short constant-one sweep.
module tb_puf_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, start1;
  logic         busy, done, puf_run, puf_result;
  logic [255:0] signature;
  logic [7:0]   puf_challenge;
  logic         busy1, done1, run1;
  logic [255:0] sig1;
  logic [7:0]   chal1;

  // Behavioural PUF: result is challenge[0] delayed by two clocks.
  logic [1:0] dly = '0;
  always @(posedge clk) dly <= {dly[0], puf_challenge[0]};
  assign puf_result = dly[1];

  puf_sweep_ctrl #(.PUF_LENGTH(8), .RUN_CYCLES(10), .SETTLE_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .signature(signature), .puf_challenge(puf_challenge), .puf_run(puf_run),
    .puf_result(puf_result)
  );

  puf_sweep_ctrl #(.PUF_LENGTH(8), .RUN_CYCLES(1), .SETTLE_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .signature(sig1), .puf_challenge(chal1), .puf_run(run1),
    .puf_result(1'b1)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Handshake monitor on the default-parameter instance:
  // challenge stable while run is high, run high exactly 10 cycles,
  // run low exactly 11 cycles (settle + sample) before each new challenge/done.
  logic        mon_run, mon_busy;
  logic [7:0]  mon_chal;
  int unsigned low_cnt, high_cnt, viol_stab, viol_settle, viol_run, done_cnt;

  always @(negedge clk) begin
    if (reset) begin
      mon_run <= 1'b0; mon_busy <= 1'b0; mon_chal <= '0;
      low_cnt <= 0; high_cnt <= 0; done_cnt <= 0;
    end else begin
      if (puf_run && mon_run && puf_challenge != mon_chal) viol_stab <= viol_stab + 1;
      if (busy && mon_busy && puf_challenge != mon_chal && low_cnt != 11) viol_settle <= viol_settle + 1;
      if (done && low_cnt != 11) viol_settle <= viol_settle + 1;
      if (low_cnt < 3 && done) viol_settle <= viol_settle + 1;
      if (mon_run && !puf_run && high_cnt != 10) viol_run <= viol_run + 1;
      low_cnt  <= (busy && !puf_run) ? low_cnt + 1 : 0;
      high_cnt <= puf_run ? high_cnt + 1 : 0;
      if (done) done_cnt <= done_cnt + 1;
      mon_run  <= puf_run;
      mon_busy <= busy;
      mon_chal <= puf_challenge;
    end
  end

  initial begin
    viol_stab = 0; viol_settle = 0; viol_run = 0;
  end

  initial begin
    int unsigned cyc;
    bit          pulsed;
    reset = 1'b1; start = 1'b0; start1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_run",  puf_run, 1'b0);
    check("rst_chal", puf_challenge, 8'h00);
    check("rst_sig",  signature, '0);
    @(negedge clk) reset = 1'b0;

    // Abort mid-RUN at challenge 0x37 with an asynchronous reset.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (!(puf_run && puf_challenge == 8'h37) && cyc < 3000) begin
      @(negedge clk); cyc++;
    end
    check("reach_37", puf_challenge, 8'h37);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_run",  puf_run, 1'b0);
    check("abort_chal", puf_challenge, 8'h00);
    check("abort_sig",  signature, '0);
    check("abort_done", done, 1'b0);
    @(negedge clk);
    @(negedge clk) reset = 1'b0;

    // Full LSB sweep; stray start during RUN of challenge 5 and during FINISH.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("t1_busy", busy, 1'b1);
    check("t1_run",  puf_run, 1'b1);
    check("t1_chal", puf_challenge, 8'h00);
    check("t1_sig",  signature, '0);
    cyc = 1; pulsed = 1'b0;
    while (!done && cyc < 6000) begin
      @(negedge clk); cyc++;
      if (!pulsed && puf_run && puf_challenge == 8'h05) begin
        start = 1'b1; pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check("lsb_latency", cyc, 5377);
    check("lsb_sig", signature, {64{4'hA}});
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("fin_start_busy", busy, 1'b0);
    check("fin_start_run",  puf_run, 1'b0);
    check("fin_start_done", done, 1'b0);
    repeat (5) @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_done_cnt", done_cnt, 1);
    check("idle_sig_hold", signature, {64{4'hA}});

    // Second sweep from IDLE clears the signature and restarts at 0.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("s2_busy", busy, 1'b1);
    check("s2_run",  puf_run, 1'b1);
    check("s2_chal", puf_challenge, 8'h00);
    check("s2_sig",  signature, '0);
    cyc = 1;
    while (!done && cyc < 6000) begin
      @(negedge clk); cyc++;
    end
    check("s2_latency", cyc, 5377);
    check("s2_sig_final", signature, {64{4'hA}});

    // Constant-one sweep, RUN_CYCLES=1, SETTLE_CYCLES=3.
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    check("one_busy", busy1, 1'b1);
    cyc = 1;
    while (!done1 && cyc < 2000) begin
      @(negedge clk); cyc++;
    end
    check("one_latency", cyc, 1281);
    check("one_sig", sig1, {256{1'b1}});

    @(negedge clk);
    check("hs_chal_stable", viol_stab, 0);
    check("hs_settle_low",  viol_settle, 0);
    check("hs_run_len",     viol_run, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/puf_sweep_ctrl.md
# puf_sweep_ctrl

Hardware sweep controller sitting directly upstream of `DelayPUF`. It steps through every challenge, pulses `run` for each one and samples the synchronized `result`. The responses are packed into a 2^PUF_LENGTH-bit signature register. It replaces the sweep loop currently done in simulation, so enrollment and readout run on silicon with one `start` pulse.

## Interface
Parameters:
- `PUF_LENGTH`, 8: challenge width; signature width is `SIG_W` = 2^PUF_LENGTH.
- `RUN_CYCLES`, 10: cycles `puf_run` is held high per challenge; must be ≥1.
- `SETTLE_CYCLES`, 10: low cycles before sampling; must be ≥3 to cover DelayPUF's 2-flop synchronizer plus margin; elaboration error otherwise.

Ports:
- `clk` input 1: single clock, also drives DelayPUF's synchronizers.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: one-cycle request to begin a sweep.
- `busy` output 1: high from the cycle after `start` is accepted until `done`.
- `done` output 1: one-cycle pulse after the final sample.
- `signature` output SIG_W: collected responses; bit i is the response to challenge i.
- `puf_challenge` output PUF_LENGTH: to DelayPUF `challenge`.
- `puf_run` output 1: to DelayPUF `run`.
- `puf_result` input 1: from DelayPUF `result`, already synchronized.

## Operation
- States: IDLE, RUN, SETTLE, SAMPLE, FINISH.
- **IDLE**
  - `start`=1 → RUN.
  - On that edge: challenge counter ← 0, phase counter ← 0, signature ← 0.
- **RUN**
  - `puf_run`=1.
  - After RUN_CYCLES cycles → SETTLE; phase counter reset.
- **SETTLE**
  - `puf_run`=0; `puf_challenge` held stable.
  - After SETTLE_CYCLES cycles → SAMPLE.
- **SAMPLE** (one cycle)
  - Shift: `signature` ← {puf_result, signature[SIG_W-1:1]}.
  - If challenge == all-ones → FINISH.
  - Otherwise: challenge += 1 → RUN.
- **FINISH** (one cycle)
  - `done`=1, `busy`=0 → IDLE.
- `signature` holds its value in IDLE until the next accepted `start`.
- `start` while busy: ignored; no restart, no queueing.
- `start` in the same cycle as FINISH: ignored; must be re-issued in IDLE.
- `puf_challenge` changes only on the SAMPLE→RUN edge, never while `puf_run`=1.
- Counters:
  - Challenge counter: PUF_LENGTH bits; terminates via the all-ones compare, no wrap.
  - Phase counter: $clog2(max(RUN_CYCLES, SETTLE_CYCLES)+1) bits.

## Timing
- Reset values: state=IDLE; `busy`=0, `done`=0, `puf_run`=0, `puf_challenge`=0, `signature`=0.
- Reset mid-sweep: immediate abort to reset values; partial signature discarded; DelayPUF sees `run` fall asynchronously.
- `start` sampled at edge T: first RUN cycle is T+1; `busy`=1 and `puf_run`=1 from T+1.
- Per challenge: P = RUN_CYCLES + SETTLE_CYCLES + 1 cycles.
- `done` high at cycle T + SIG_W·P + 1. With defaults this is T+5377.
- Final `signature` is valid in the same cycle `done` is high.
- `puf_result` sampled in SAMPLE is the value after SETTLE_CYCLES low cycles. The controller adds no latency of its own beyond the shift.

## Structure
- Shared package `puf_pkg`: state enum `sweep_state_t`, default `PUF_LENGTH`, `SIG_W` function, `MIN_SETTLE`=3.
- Single flat module. No sub-module needed beyond an optional `phase_counter`; inline is preferred.
- Integration top `puf_top` instantiates `puf_sweep_ctrl` + `DelayPUF`. Out of scope here.

## Test plan
- **Reset values**: reset asserted mid-RUN at challenge 0x37 → all outputs zero asynchronously; new `start` restarts at challenge 0.
- **Challenge-LSB sweep**: behavioural PUF model with `puf_result` = challenge[0] delayed 2 clocks, defaults → `signature` = 256'hAAAA…AAAA; `done` exactly 5377 cycles after `start`.
- **Constant-one sweep**: model result=1, `RUN_CYCLES`=1, `SETTLE_CYCLES`=3 → `signature` = all ones; `done` at T+256·5+1.
- **Start handling**: `start` pulsed during RUN of challenge 5 and again during FINISH → both ignored; no restart, single `done`; second sweep only after `start` in IDLE.
- **Handshake checks**: assertion that `puf_challenge` is stable whenever `puf_run`=1, and that `puf_run` is low ≥3 cycles before every SAMPLE.
- **Integration with hard-coded-delay DelayPUF** (#2,#1,#3,#4,#5,#4,#5,#5,#3,#6,#5,#6,#4,#3,#5,#6,#3,#3), with `RUN_CYCLES` and `SETTLE_CYCLES` chosen so each phase lasts at least 100 ns (≥10 cycles at the 10 ns clock) → `signature` = 256'heffeffff1001effe000000004bb4ffff10010000effe1001ffffffffb44b.
